// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting four requesters write access to one shared register.
// Optional macro ARB_TIMEOUT_EN limits each grant to MAX_HOLD consecutive writes.
module reg_write_arbiter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] din,
    input  logic               set,
    output logic [3:0]         gnt,
    output logic [1:0]         owner,
    output logic               busy,
    output logic [WIDTH-1:0]   q
);

    typedef enum logic {IDLE, GRANT} state_t;

    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_hold_range_check
        $error("MAX_HOLD must be in 1..15");
    end

    state_t           state, state_n;
    logic [1:0]       ptr, ptr_n, owner_n, winner;
    logic [3:0]       gnt_n;
    logic             busy_n;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] lane [4];
    logic             write, rel, do_grant;

`ifdef ARB_TIMEOUT_EN
    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);
    logic [3:0] hold_cnt, hold_n;
`endif

    // First set request bit searching ptr+1, ptr+2, ptr+3, ptr.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        pick = p;
        for (int k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (r[idx]) pick = idx;
        end
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) lane[i] = din[i*WIDTH +: WIDTH];
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        owner_n  = owner;
        gnt_n    = gnt;
        busy_n   = busy;
        q_n      = q;
        winner   = pick(req, ptr);
        write    = 1'b0;
        rel      = 1'b0;
        do_grant = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_n   = hold_cnt;
`endif
        case (state)
            IDLE: begin
                do_grant = |req;
            end
            GRANT: begin
                write = req[owner];
                if (write) begin
                    q_n = lane[owner];
`ifdef ARB_TIMEOUT_EN
                    hold_n = hold_cnt + 4'd1;
`endif
                end
`ifdef ARB_TIMEOUT_EN
                rel = !write || (hold_n == HOLD_MAX);
`else
                rel = !write;
`endif
                if (rel) begin
                    if (|req) begin
                        do_grant = 1'b1;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = 4'b0000;
                        busy_n  = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 4'b0000;
                busy_n  = 1'b0;
            end
        endcase

        if (do_grant) begin
            state_n = GRANT;
            ptr_n   = winner;
            owner_n = winner;
            gnt_n   = 4'b0001 << winner;
            busy_n  = 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_n  = 4'd0;
`endif
        end

        // Preset wins over a same-edge write.
        if (set) q_n = '1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= 2'd3;
            owner    <= 2'd0;
            gnt      <= 4'b0000;
            busy     <= 1'b0;
            q        <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= 4'd0;
`endif
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
            gnt      <= gnt_n;
            busy     <= busy_n;
            q        <= q_n;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= hold_n;
`endif
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboarded random/directed bench for reg_write_arbiter against a behavioural model.
module tb_reg_write_arbiter;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned MAX_HOLD = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [3:0]         req = 4'b0000;
    logic [4*WIDTH-1:0] din = '0;
    logic               set = 1'b0;
    logic [3:0]         gnt;
    logic [1:0]         owner;
    logic               busy;
    logic [WIDTH-1:0]   q;

    reg_write_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset), .req(req), .din(din), .set(set),
        .gnt(gnt), .owner(owner), .busy(busy), .q(q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       gnt;
        logic             busy;
        logic [1:0]       owner;
        logic [WIDTH-1:0] q;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 1'b0;

    // Model state in plain integers.
    int m_busy  = 0;
    int m_owner = 0;
    int m_ptr   = 3;
    int m_hold  = 0;
    int m_q     = 0;

    function automatic int pick_winner(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return p;
    endfunction

    task automatic model_grant(input logic [3:0] r);
        m_owner = pick_winner(r, m_ptr);
        m_ptr   = m_owner;
        m_busy  = 1;
        m_hold  = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic [4*WIDTH-1:0] d,
                              input logic s, input logic rst_n);
        exp_t e;
        int   qn;
        bit   wrote, released;
        if (!rst_n) begin
            m_busy = 0; m_owner = 0; m_ptr = 3; m_hold = 0; m_q = 0;
        end else begin
            qn = m_q;
            if (m_busy == 0) begin
                if (r != 4'b0000) model_grant(r);
            end else begin
                wrote = r[m_owner];
                if (wrote) begin
                    qn = int'((d >> (m_owner * WIDTH)) & 16'hF);
                    m_hold++;
                end
                released = !wrote;
`ifdef ARB_TIMEOUT_EN
                if (wrote && m_hold == MAX_HOLD) released = 1'b1;
`endif
                if (released) begin
                    if (r != 4'b0000) model_grant(r);
                    else m_busy = 0;
                end
            end
            if (s) qn = (1 << WIDTH) - 1;
            m_q = qn;
        end
        e.busy  = (m_busy != 0);
        e.gnt   = e.busy ? (4'b0001 << m_owner) : 4'b0000;
        e.owner = 2'(m_owner);
        e.q     = WIDTH'(m_q);
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [3:0] r, input logic [4*WIDTH-1:0] d,
                         input logic s, input logic rst_n);
        @(posedge clk);
        #2;
        req = r; din = d; set = s; reset = rst_n;
        model_step(r, d, s, rst_n);
    endtask

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: compares outputs just after every edge that has a pending expectation.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("gnt", int'(gnt), int'(e.gnt));
                check("busy", int'(busy), int'(e.busy));
                check("q", int'(q), int'(e.q));
                if (e.busy) check("owner", int'(owner), int'(e.owner));
                check("busy_eq_or_gnt", int'(busy), int'(|gnt));
                check("gnt_onehot0", int'($onehot0(gnt)), 1);
            end
        end
    end

    initial begin
        logic [3:0] r;
        logic       s, rst_n;
        int         wait_cycles;

        drive(4'b0000, '0, 1'b0, 1'b0);
        drive(4'b0000, '0, 1'b1, 1'b0);

        // Single requester 2 with lane2 = A.
        repeat (4) drive(4'b0100, 16'h0A00, 1'b0, 1'b1);
        // Preset during an owner write, then the write resumes.
        drive(4'b0100, 16'h0300, 1'b1, 1'b1);
        drive(4'b0100, 16'h0300, 1'b0, 1'b1);
        drive(4'b0000, '0, 1'b0, 1'b1);

        // Owner 1 drops while requester 3 waits.
        repeat (2) drive(4'b0010, 16'h00B0, 1'b0, 1'b1);
        repeat (2) drive(4'b1010, 16'h00C0, 1'b0, 1'b1);
        repeat (3) drive(4'b1000, 16'h7000, 1'b0, 1'b1);

        // Reset in the middle of a grant, then fresh search from requester 0.
        drive(4'b1000, 16'h5000, 1'b0, 1'b1);
        drive(4'b1000, 16'h5000, 1'b0, 1'b0);
        repeat (2) drive(4'b1001, 16'h6002, 1'b0, 1'b1);
        drive(4'b0000, '0, 1'b0, 1'b1);

        // Two requesters held; timeout behaviour depends on the build.
        repeat (20) drive(4'b0011, 16'($urandom), 1'b0, 1'b1);
        drive(4'b0000, '0, 1'b0, 1'b1);

        // All requesting: rotation.
        repeat (24) drive(4'b1111, 16'($urandom), 1'b0, 1'b1);

        // Randomized traffic with sticky request bits.
        r = 4'b0000;
        for (int n = 0; n < 1500; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            s     = ($urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            drive(r, 16'($urandom), s, rst_n);
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #3;
        check("scoreboard_drained", exp_q.size(), 0);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, bit width of shared register and each requester data lane.
REQ-002 Parameter MAX_HOLD, default 4, maximum consecutive write cycles per grant (range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req  input  4  per-requester write request, bit i = requester i.
REQ-006 din  input  4*WIDTH  requester data, lane i = din[i*WIDTH +: WIDTH].
REQ-007 set  input  1  synchronous preset of shared register to all ones.
REQ-008 gnt  output  4  registered one-hot grant, all zero when idle.
REQ-009 owner  output  2  registered index of current grant holder, valid when busy=1.
REQ-010 busy  output  1  registered, high while state is GRANT.
REQ-011 q  output  WIDTH  registered shared register contents.

Function
REQ-012 FSM SHALL have exactly two states: IDLE, GRANT.
REQ-013 IDLE: gnt=0; if req!=0 at an edge, SHALL enter GRANT at that edge with gnt=onehot(winner), owner=winner, hold_cnt=0.
REQ-014 Winner SHALL be the first set req bit searching ptr+1, ptr+2, ptr+3, ptr (mod 4); ptr SHALL update to winner on every grant.
REQ-015 GRANT, edge with req[owner]=1: q SHALL load din lane owner; hold_cnt SHALL increment.
REQ-016 Grant-to-first-write latency: first q update at the edge after gnt rises; req-to-gnt latency 1 cycle from IDLE.
REQ-017 Release SHALL occur at an edge where req[owner]=0 (no write that edge) or where the write brings hold_cnt to MAX_HOLD (write performed).
REQ-018 On release, if any req bit set (sampled that edge), SHALL re-arbitrate per REQ-014 and stay in GRANT with new gnt (no idle bubble); else enter IDLE with gnt=0.
REQ-019 Timeout release with only owner requesting SHALL regrant same owner with hold_cnt=0.
REQ-020 set=1 SHALL force q to all ones, overriding any write that edge; FSM, gnt, hold_cnt unaffected.
REQ-021 gnt SHALL never have more than one bit set; busy SHALL equal |gnt.
REQ-022 req changes of non-owners during GRANT SHALL not affect current grant.

Reset
REQ-023 reset=0 at an edge SHALL set: state IDLE, gnt=0, owner=0, busy=0, q=0, hold_cnt=0, ptr=3.
REQ-024 reset SHALL override set and any write; reset mid-GRANT drops gnt at that edge.
REQ-025 First grant after reset SHALL search from requester 0.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN defined: MAX_HOLD release per REQ-017/REQ-019 enforced.
REQ-027 ARB_TIMEOUT_EN undefined: hold_cnt logic absent; owner keeps grant until req[owner]=0; MAX_HOLD ignored.

Verification
REQ-028 After reset, req=4'b0100 held, din lane2=4'hA -> gnt=4'b0100 next edge, q=4'hA one edge later, busy=1.
REQ-029 req=4'b1111 held, ARB_TIMEOUT_EN, MAX_HOLD=4 -> grants cycle 0,1,2,3,0, each exactly 4 writes, no gnt=0 cycle between.
REQ-030 Owner 1 drops req while req=4'b1010 -> next gnt=4'b1000 at same release edge, q holds last lane1 value.
REQ-031 set=1 during owner write of 4'h3 -> q=4'hF that edge; next write loads 4'h3.
REQ-032 reset=0 mid-GRANT with q=4'h5 -> gnt=0, busy=0, q=0 next edge; after release req=4'b1001 -> gnt=4'b0001.
REQ-033 ARB_TIMEOUT_EN undefined, req=4'b0011 held 20 cycles -> gnt=4'b0001 throughout, 19 writes from lane0.
